iob_clint_arbiter: RTL and testbench

- Round-robin arbiter that shares one CLINT native-bus slave port among N_MASTERS requesters (cores, debug module, DMA).
- Serialises transactions: at most one request is outstanding at the slave at any time.
- Issues each slave request as a single-cycle valid pulse, waits for the slave's ready, then returns rdata and a ready pulse to the granted master.
- Sits between the core-side interconnect and the CLINT.
- Includes a response timeout so a missing slave cannot hang a master.

---
 rtl/iob_clint_arbiter_pkg.sv | 28 ++
 rtl/iob_rr_select.sv | 42 ++++
 rtl/iob_clint_arbiter.sv | 125 ++++++++++++
 tb/tb_iob_clint_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_clint_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iob_clint_arbiter_pkg
// Description : Shared FSM state encoding and sizing helper for the CLINT
//               native-bus round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package iob_clint_arbiter_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  // Ceiling log2 that never returns less than one bit, so degenerate
  // configurations (one master, timeout disabled) still get legal vectors.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iob_rr_select.sv
`default_nettype none
// ============================================================================
// Module      : iob_rr_select
// Description : Combinational round-robin picker. Returns the first set
//               request bit at or above ptr, wrapping around to bit 0.
// Revision    : 1.0 - initial release
// ============================================================================
module iob_rr_select
  import iob_clint_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  // Duplicate the request vector, mask the low copy below ptr, and take the
  // lowest surviving bit; a hit in the upper copy is the wrapped-around case.
  always_comb begin
    dbl     = {req, req};
    masked  = '0;
    gnt_idx = '0;
    for (int i = 0; i < 2 * N; i++) begin
      masked[i] = dbl[i] && (i >= int'(ptr));
    end
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (masked[i]) begin
        gnt_idx = (i >= N) ? PTR_W'(i - N) : PTR_W'(i);
      end
    end
  end

  assign any = |req;

endmodule
`default_nettype wire

// File: rtl/iob_clint_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : iob_clint_arbiter
// Description : Round-robin arbiter sharing one CLINT native-bus slave port
//               among N_MASTERS requesters. One transaction outstanding at a
//               time, single-cycle slave valid, response timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module iob_clint_arbiter
  import iob_clint_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_MASTERS-1:0]            m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_address,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
  input  logic [N_MASTERS*(DATA_W/8)-1:0] m_wstrb,
  output logic [DATA_W-1:0]               m_rdata,
  output logic [N_MASTERS-1:0]            m_ready,
  output logic                            m_err,
  output logic                            s_valid,
  output logic [ADDR_W-1:0]               s_address,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_wstrb,
  input  logic [DATA_W-1:0]               s_rdata,
  input  logic                            s_ready,
  output logic                            busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = clog2_min1(N_MASTERS);
  localparam int CNT_W  = clog2_min1(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [N_MASTERS-1:0] ONE_HOT0 = N_MASTERS'(1);

  arb_state_t       state;
  logic [PTR_W-1:0] prio_ptr;
  logic [PTR_W-1:0] grant;
  logic [PTR_W-1:0] sel_idx;
  logic             sel_any;
  logic [CNT_W-1:0] cnt;

  iob_rr_select #(
    .N     (N_MASTERS),
    .PTR_W (PTR_W)
  ) u_rr_select (
    .req     (m_valid),
    .ptr     (prio_ptr),
    .gnt_idx (sel_idx),
    .any     (sel_any)
  );

  // Grant, issue one slave pulse, wait for ready or timeout, then return the
  // response to the granted master and rotate priority past it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prio_ptr  <= '0;
      grant     <= '0;
      cnt       <= '0;
      s_valid   <= 1'b0;
      s_address <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      m_rdata   <= '0;
      m_ready   <= '0;
      m_err     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_any) begin
            grant     <= sel_idx;
            s_address <= m_address[int'(sel_idx)*ADDR_W +: ADDR_W];
            s_wdata   <= m_wdata[int'(sel_idx)*DATA_W +: DATA_W];
            s_wstrb   <= m_wstrb[int'(sel_idx)*STRB_W +: STRB_W];
            s_valid   <= 1'b1;
            busy      <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          s_valid <= 1'b0;
          cnt     <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (s_ready) begin
            m_rdata <= s_rdata;
            m_err   <= 1'b0;
            m_ready <= ONE_HOT0 << grant;
            state   <= RESP;
          end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
            m_rdata <= '0;
            m_err   <= 1'b1;
            m_ready <= ONE_HOT0 << grant;
            state   <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          m_ready <= '0;
          m_err   <= 1'b0;
          busy    <= 1'b0;
          if (int'(grant) == N_MASTERS - 1) begin
            prio_ptr <= '0;
          end else begin
            prio_ptr <= grant + 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iob_clint_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_iob_clint_arbiter
// Description : Scoreboard bench for iob_clint_arbiter with four masters, a
//               variable-latency CLINT slave model and a timeout of 4 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_clint_arbiter;

  localparam int NM = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic             clk;
  logic             rst;
  logic [NM-1:0]    m_valid;
  logic [NM*AW-1:0] m_address;
  logic [NM*DW-1:0] m_wdata;
  logic [NM*SW-1:0] m_wstrb;
  logic [DW-1:0]    m_rdata;
  logic [NM-1:0]    m_ready;
  logic             m_err;
  logic             s_valid;
  logic [AW-1:0]    s_address;
  logic [DW-1:0]    s_wdata;
  logic [SW-1:0]    s_wstrb;
  logic [DW-1:0]    s_rdata;
  logic             s_ready;
  logic             busy;

  iob_clint_arbiter #(
    .N_MASTERS (NM),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_valid   (m_valid),
    .m_address (m_address),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready),
    .m_err     (m_err),
    .s_valid   (s_valid),
    .s_address (s_address),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_rdata   (s_rdata),
    .s_ready   (s_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s; } sreq_t;
  typedef struct { int m; logic [DW-1:0] rd; bit err; } resp_t;

  sreq_t exp_s[$];
  resp_t exp_r[$];
  int    lat_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // batch stimulus: per master up to 4 back-to-back requests
  logic [AW-1:0] b_addr [NM][4];
  logic [DW-1:0] b_wdata[NM][4];
  logic [SW-1:0] b_wstrb[NM][4];
  int            b_cnt  [NM];
  int            model_ptr = 0;

  bit slave_dead = 0;
  bit stray_en = 0;
  bit force_ready = 0;
  int slave_lat_max = 3;
  bit chk_start = 0;
  int t_req = 0;
  bit gap_chk = 0;
  int t_rdy = 0;
  int t_sv = 0;
  bit sv_prev = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // CLINT-like read data: a fixed timer word at 0xBFF8, else address-derived
  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    if (a == 16'hBFF8) return 32'h0000_1234;
    return {a ^ 16'hC3C3, ~a};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: ready 1..slave_lat_max cycles after s_valid, optional strays
  initial begin
    int pend;
    logic [AW-1:0] lat_addr;
    pend = 0;
    lat_addr = '0;
    s_ready = 1'b0;
    s_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      s_ready = 1'b0;
      if (rst) pend = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          s_ready = 1'b1;
          s_rdata = slave_data(lat_addr);
          chk(s_address === lat_addr, "s_address_stable", 64'(s_address), 64'(lat_addr));
        end
      end else if (s_valid && !slave_dead && !rst) begin
        pend = $urandom_range(1, slave_lat_max);
        lat_addr = s_address;
        lat_q.push_back(pend);
      end else if (stray_en && !busy && !s_valid && ($urandom_range(0, 3) == 0)) begin
        s_ready = 1'b1;
        s_rdata = $urandom;
      end
      if (force_ready) begin
        s_ready = 1'b1;
        s_rdata = 32'hBAD0_0000;
      end
    end
  end

  // Monitor: compare every slave request and every master response
  always @(negedge clk) begin
    if (!rst) begin
      if (s_valid) begin
        chk(!sv_prev, "s_valid_single_cycle", 64'(sv_prev), 64'd0);
        if (exp_s.size() == 0) begin
          chk(1'b0, "unexpected_s_valid", 64'(s_address), 64'd0);
        end else begin
          sreq_t e;
          e = exp_s.pop_front();
          chk({s_address, s_wdata, s_wstrb} === {e.a, e.d, e.s}, "slave_request",
              64'({s_address, s_wdata, s_wstrb}), 64'({e.a, e.d, e.s}));
        end
        if (chk_start) begin
          chk(cyc - t_req == 1, "first_s_valid_latency", 64'(cyc - t_req), 64'd1);
          chk_start = 0;
        end
        if (gap_chk) begin
          chk(cyc - t_rdy == 2, "back_to_back_gap", 64'(cyc - t_rdy), 64'd2);
          gap_chk = 0;
        end
        t_sv = cyc;
      end
      sv_prev = s_valid;
      if (|m_ready) begin
        chk($onehot(m_ready), "m_ready_onehot", 64'(m_ready), 64'd0);
        if (exp_r.size() == 0) begin
          chk(1'b0, "unexpected_m_ready", 64'(m_ready), 64'd0);
        end else begin
          resp_t r;
          int exp_lat;
          r = exp_r.pop_front();
          chk(m_ready === (NM'(1) << r.m), "grant_order", 64'(m_ready), 64'(NM'(1) << r.m));
          chk(m_rdata === r.rd, "m_rdata", 64'(m_rdata), 64'(r.rd));
          chk(m_err === r.err, "m_err", 64'(m_err), 64'(r.err));
          if (r.err) exp_lat = TO + 1;
          else exp_lat = (lat_q.size() > 0) ? lat_q.pop_front() + 1 : -1;
          chk(cyc - t_sv == exp_lat, "response_latency", 64'(cyc - t_sv), 64'(exp_lat));
        end
        gap_chk = (exp_s.size() > 0);
        t_rdy = cyc;
      end
    end else begin
      sv_prev = 0;
    end
  end

  task automatic clear_batch();
    for (int i = 0; i < NM; i++) begin
      b_cnt[i] = 0;
      for (int j = 0; j < 4; j++) begin
        b_addr[i][j]  = AW'($urandom) & 16'hFFFC;
        b_wdata[i][j] = $urandom;
        b_wstrb[i][j] = ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom);
      end
    end
  endtask

  task automatic present(input int i, input int p);
    if (p < b_cnt[i]) begin
      m_valid[i] = 1'b1;
      m_address[i*AW +: AW] = b_addr[i][p];
      m_wdata[i*DW +: DW]   = b_wdata[i][p];
      m_wstrb[i*SW +: SW]   = b_wstrb[i][p];
    end else begin
      m_valid[i] = 1'b0;
    end
  endtask

  // Reference: every master with work left re-requests immediately, so each
  // grant is the first master with work left counting up from the pointer.
  task automatic run_batch(input bit dead);
    int left[NM];
    int pos[NM];
    int p, total, done, guard;
    slave_dead = dead;
    total = 0;
    for (int i = 0; i < NM; i++) begin
      left[i] = b_cnt[i];
      pos[i] = 0;
      total += b_cnt[i];
    end
    p = model_ptr;
    for (int t = 0; t < total; t++) begin
      int g;
      g = -1;
      for (int k = 0; k < NM; k++) begin
        if (g < 0 && left[(p + k) % NM] > 0) g = (p + k) % NM;
      end
      exp_s.push_back('{b_addr[g][pos[g]], b_wdata[g][pos[g]], b_wstrb[g][pos[g]]});
      exp_r.push_back('{g, dead ? '0 : slave_data(b_addr[g][pos[g]]), dead});
      left[g]--;
      pos[g]++;
      p = (g + 1) % NM;
    end
    model_ptr = p;
    @(negedge clk);
    for (int i = 0; i < NM; i++) begin
      pos[i] = 0;
      present(i, 0);
    end
    if (total > 0) begin
      chk_start = 1;
      t_req = cyc;
    end
    done = 0;
    guard = 0;
    while (done < total && guard < total * 20 + 20) begin
      @(negedge clk);
      guard++;
      for (int i = 0; i < NM; i++) begin
        if (m_ready[i]) begin
          done++;
          pos[i]++;
          present(i, pos[i]);
        end
      end
    end
    chk(done == total, "batch_completion", 64'(done), 64'(total));
    m_valid = '0;
    repeat (3) @(negedge clk);
    chk_start = 0;
    slave_dead = 0;
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    m_valid = '0;
    m_address = '0;
    m_wdata = '0;
    m_wstrb = '0;
    repeat (3) @(negedge clk);
    chk({s_valid, s_address, s_wdata, s_wstrb, busy} == '0, "reset_slave_side",
        64'({s_valid, s_address, s_wdata, s_wstrb, busy}), 64'd0);
    chk({m_rdata, m_ready, m_err} == '0, "reset_master_side",
        64'({m_rdata, m_ready, m_err}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // contention from reset, 1-cycle slave: grants 0,1,0,1 spaced 4 cycles
    slave_lat_max = 1;
    clear_batch();
    b_cnt[0] = 2;
    b_cnt[1] = 2;
    run_batch(0);

    // single read of the timer word
    clear_batch();
    b_cnt[0] = 1;
    b_addr[0][0] = 16'hBFF8;
    b_wdata[0][0] = '0;
    b_wstrb[0][0] = '0;
    run_batch(0);

    // single write from master 1
    clear_batch();
    b_cnt[1] = 1;
    b_addr[1][0] = 16'h4000;
    b_wdata[1][0] = 32'hDEAD_BEEF;
    b_wstrb[1][0] = 4'hF;
    run_batch(0);

    // fairness: grant master 2 alone, then {0,2,3} from pointer 3
    clear_batch();
    b_cnt[2] = 1;
    run_batch(0);
    clear_batch();
    b_cnt[0] = 1;
    b_cnt[2] = 1;
    b_cnt[3] = 1;
    run_batch(0);

    // timeout with a dead slave, then a normal request
    clear_batch();
    b_cnt[0] = 1;
    run_batch(1);
    clear_batch();
    b_cnt[0] = 1;
    run_batch(0);

    // randomized batches with variable latency, strays and occasional timeouts
    slave_lat_max = 3;
    stray_en = 1;
    repeat (25) begin
      clear_batch();
      for (int i = 0; i < NM; i++) b_cnt[i] = $urandom_range(0, 3);
      run_batch($urandom_range(0, 5) == 0);
    end
    stray_en = 0;

    // reset while waiting on a dead slave, then a late s_ready
    slave_dead = 1;
    clear_batch();
    @(negedge clk);
    m_address[AW-1:0] = 16'h0BF0;
    m_wdata[DW-1:0] = '0;
    m_wstrb[SW-1:0] = '0;
    m_valid = 4'b0001;
    exp_s.push_back('{16'h0BF0, 32'h0, 4'h0});
    exp_r.push_back('{0, 32'h0, 1'b1});
    chk_start = 1;
    t_req = cyc;
    for (int g = 0; g < 10 && !s_valid; g++) @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk(busy === 1'b1, "busy_in_wait", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk({s_valid, s_address, s_wdata, s_wstrb, busy} == '0, "reset_in_wait_slave_side",
        64'({s_valid, s_address, s_wdata, s_wstrb, busy}), 64'd0);
    chk({m_rdata, m_ready, m_err} == '0, "reset_in_wait_master_side",
        64'({m_rdata, m_ready, m_err}), 64'd0);
    m_valid = '0;
    exp_r.delete();
    gap_chk = 0;
    chk_start = 0;
    model_ptr = 0;
    @(negedge clk);
    rst = 1'b0;
    slave_dead = 0;
    force_ready = 1;
    @(negedge clk);
    force_ready = 0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (|m_ready) pulses++;
    end
    chk(pulses == 0, "late_s_ready_ignored", 64'(pulses), 64'd0);

    // normal traffic resumes from priority 0
    clear_batch();
    b_cnt[1] = 1;
    b_cnt[3] = 2;
    run_batch(0);

    chk(exp_s.size() == 0 && exp_r.size() == 0, "scoreboard_drained",
        64'(exp_s.size() + exp_r.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
